sram_bridge: RTL and testbench

SRAM_BRIDGE -- requirements
Module: sram_bridge

---
 rtl/sram_bridge_pkg.sv | 19 +
 rtl/wr_fifo.sv | 72 +++++++
 rtl/sram_bridge.sv | 139 +++++++++++++
 tb/tb_sram_bridge.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bridge_pkg.sv
// rtl/sram_bridge_pkg.sv - shared FSM encoding, entry layout and defaults for sram_bridge
package sram_bridge_pkg;

  localparam int WS_DEFAULT    = 1;
  localparam int DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PULSE = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_entry_t;

endpackage

// File: rtl/wr_fifo.sv
// rtl/wr_fifo.sv - posted-write FIFO with youngest-match address lookup for read forwarding
module wr_fifo
  import sram_bridge_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  wr_entry_t   push_entry,
  input  logic        pop,
  output wr_entry_t   head,
  output logic        empty,
  output logic        full,
  output logic        accepted,
  input  logic [15:0] lookup_addr,
  output logic        lookup_hit,
  output logic [7:0]  lookup_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  wr_entry_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic        do_pop;
  logic        do_push;

  // Extra MSB on each pointer separates full (MSBs differ) from empty (equal).
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign accepted = do_push;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  // Walk oldest to youngest so the last match (youngest) wins.
  logic [AW:0] off;
  logic [AW:0] idx;
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    off         = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = i[AW:0];
      idx = rd_ptr + off;
      if ((off < count) && (mem[idx[AW-1:0]].addr == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = mem[idx[AW-1:0]].data;
      end
    end
  end

endmodule

// File: rtl/sram_bridge.sv
// rtl/sram_bridge.sv - SoC bus to asynchronous SRAM bridge with posted writes and read forwarding
module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int WS    = WS_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic        sram_oe,
  input  logic [7:0]  sram_dout,
  output logic [7:0]  sram_din,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_dq_o,
  output logic        ext_dq_oe,
  input  logic [7:0]  ext_dq_i,
  output logic        ext_ce_n,
  output logic        ext_oe_n,
  output logic        ext_we_n,
  output logic        ovf
);

  localparam logic [1:0] PULSE_LOAD = 2'(WS - 1);

  state_t     state;
  state_t     state_nx;
  logic [1:0] pulse_cnt;
  logic [1:0] pulse_cnt_nx;
  wr_entry_t  inflight;
  logic       active;
  logic       fifo_pop;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_accepted;
  logic       fifo_hit;
  logic [7:0] fifo_data;
  wr_entry_t  fifo_head;
  logic       inflight_hit;
  logic [7:0] din_nx;

  wr_fifo #(.DEPTH(DEPTH)) u_wr_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (sram_oe),
    .push_entry  ({addr, sram_dout}),
    .pop         (fifo_pop),
    .head        (fifo_head),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .accepted    (fifo_accepted),
    .lookup_addr (addr),
    .lookup_hit  (fifo_hit),
    .lookup_data (fifo_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      pulse_cnt <= '0;
      inflight  <= '0;
      active    <= 1'b0;
      ovf       <= 1'b0;
      sram_din  <= 8'h00;
    end else begin
      state     <= state_nx;
      pulse_cnt <= pulse_cnt_nx;
      active    <= 1'b1;
      sram_din  <= din_nx;
      if (fifo_pop) inflight <= fifo_head;
      if (sram_oe && !fifo_accepted) ovf <= 1'b1;
    end
  end

  always_comb begin
    state_nx     = state;
    pulse_cnt_nx = pulse_cnt;
    fifo_pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_nx = ST_SETUP;
          fifo_pop = 1'b1;
        end
      end
      ST_SETUP: begin
        state_nx     = ST_PULSE;
        pulse_cnt_nx = PULSE_LOAD;
      end
      ST_PULSE: begin
        if (pulse_cnt == 2'd0) state_nx = ST_HOLD;
        else                   pulse_cnt_nx = pulse_cnt - 2'd1;
      end
      ST_HOLD: begin
        if (!fifo_empty) begin
          state_nx = ST_SETUP;
          fifo_pop = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Strobes stay in their reset levels until the first clock after reset release.
  always_comb begin
    ext_ce_n  = 1'b1;
    ext_oe_n  = 1'b1;
    ext_we_n  = 1'b1;
    ext_dq_oe = 1'b0;
    ext_addr  = 16'h0000;
    ext_dq_o  = 8'h00;
    if (active) begin
      ext_ce_n = 1'b0;
      if (state == ST_IDLE) begin
        ext_oe_n = 1'b0;
        ext_addr = addr;
      end else begin
        ext_dq_oe = 1'b1;
        ext_addr  = inflight.addr;
        ext_dq_o  = inflight.data;
        ext_we_n  = (state != ST_PULSE);
      end
    end
  end

  // Read source priority: accepted write this cycle, queued writes, in-flight write, SRAM.
  assign inflight_hit = (state != ST_IDLE) && (inflight.addr == addr);

  always_comb begin
    din_nx = sram_din;
    if (fifo_accepted)         din_nx = sram_dout;
    else if (fifo_hit)         din_nx = fifo_data;
    else if (inflight_hit)     din_nx = inflight.data;
    else if (state == ST_IDLE) din_nx = ext_dq_i;
  end

endmodule

// File: tb/tb_sram_bridge.sv
// tb/tb_sram_bridge.sv - randomized and directed bench for sram_bridge at WS=1 and WS=4
module tb_sram_bridge;

  localparam int MDEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        sram_oe;
  logic [7:0]  sram_dout;
  logic [7:0]  ext_dq_i;

  logic [7:0]  sram_din  [2];
  logic [15:0] ext_addr  [2];
  logic [7:0]  ext_dq_o  [2];
  logic        ext_dq_oe [2];
  logic        ext_ce_n  [2];
  logic        ext_oe_n  [2];
  logic        ext_we_n  [2];
  logic        ovf       [2];

  always #5 clk = ~clk;

  sram_bridge #(.WS(1), .DEPTH(MDEPTH)) u_ws1 (
    .clk(clk), .reset(reset), .addr(addr), .sram_oe(sram_oe), .sram_dout(sram_dout),
    .sram_din(sram_din[0]), .ext_addr(ext_addr[0]), .ext_dq_o(ext_dq_o[0]),
    .ext_dq_oe(ext_dq_oe[0]), .ext_dq_i(ext_dq_i), .ext_ce_n(ext_ce_n[0]),
    .ext_oe_n(ext_oe_n[0]), .ext_we_n(ext_we_n[0]), .ovf(ovf[0])
  );

  sram_bridge #(.WS(4), .DEPTH(MDEPTH)) u_ws4 (
    .clk(clk), .reset(reset), .addr(addr), .sram_oe(sram_oe), .sram_dout(sram_dout),
    .sram_din(sram_din[1]), .ext_addr(ext_addr[1]), .ext_dq_o(ext_dq_o[1]),
    .ext_dq_oe(ext_dq_oe[1]), .ext_dq_i(ext_dq_i), .ext_ce_n(ext_ce_n[1]),
    .ext_oe_n(ext_oe_n[1]), .ext_we_n(ext_we_n[1]), .ovf(ovf[1])
  );

  // Reference model: phase -1 = idle, else cycles elapsed in the current write (0 setup, 1..ws pulse, ws+1 hold)
  int          ws_of [2] = '{1, 4};
  int          phase [2];
  logic [23:0] cur   [2];
  bit          act   [2];
  bit          m_ovf [2];
  logic [7:0]  m_din [2];
  logic [23:0] q0 [$];
  logic [23:0] q1 [$];
  int          we_low [2];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [23:0] qat(input int k, input int i);
    return (k == 0) ? q0[i] : q1[i];
  endfunction

  task automatic qpush(input int k, input logic [23:0] v);
    if (k == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  task automatic qpop(input int k, output logic [23:0] v);
    if (k == 0) v = q0.pop_front();
    else        v = q1.pop_front();
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      phase[k] = -1;
      cur[k]   = '0;
      act[k]   = 1'b0;
      m_ovf[k] = 1'b0;
      m_din[k] = 8'h00;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic check_outputs();
    bit          idle;
    bit          in_pulse;
    logic [15:0] exp_addr;
    for (int k = 0; k < 2; k++) begin
      idle     = (phase[k] < 0);
      in_pulse = act[k] && !idle && (phase[k] >= 1) && (phase[k] <= ws_of[k]);
      exp_addr = !act[k] ? 16'h0000 : (idle ? addr : cur[k][23:8]);
      chk($sformatf("ws%0d_ce_n", ws_of[k]), ext_ce_n[k], !act[k]);
      chk($sformatf("ws%0d_oe_n", ws_of[k]), ext_oe_n[k], !(act[k] && idle));
      chk($sformatf("ws%0d_we_n", ws_of[k]), ext_we_n[k], !in_pulse);
      chk($sformatf("ws%0d_dq_oe", ws_of[k]), ext_dq_oe[k], act[k] && !idle);
      chk($sformatf("ws%0d_ext_addr", ws_of[k]), ext_addr[k], exp_addr);
      if (!act[k] || !idle)
        chk($sformatf("ws%0d_dq_o", ws_of[k]), ext_dq_o[k], act[k] ? cur[k][7:0] : 8'h00);
      chk($sformatf("ws%0d_sram_din", ws_of[k]), sram_din[k], m_din[k]);
      chk($sformatf("ws%0d_ovf", ws_of[k]), ovf[k], m_ovf[k]);
      if (ext_we_n[k] === 1'b0) we_low[k]++;
    end
  endtask

  task automatic model_step();
    int          sz;
    bit          pop_now;
    bit          acc;
    bit          hit;
    logic [7:0]  fwd;
    logic [23:0] e;
    for (int k = 0; k < 2; k++) begin
      sz      = qsize(k);
      pop_now = ((phase[k] < 0) || (phase[k] == ws_of[k] + 1)) && (sz > 0);
      acc     = sram_oe && ((sz < MDEPTH) || pop_now);
      hit     = 1'b0;
      fwd     = 8'h00;
      if (acc) begin
        hit = 1'b1;
        fwd = sram_dout;
      end
      for (int i = sz - 1; i >= 0; i--) begin
        e = qat(k, i);
        if (!hit && e[23:8] == addr) begin
          hit = 1'b1;
          fwd = e[7:0];
        end
      end
      if (!hit && phase[k] >= 0 && cur[k][23:8] == addr) begin
        hit = 1'b1;
        fwd = cur[k][7:0];
      end
      if (hit)              m_din[k] = fwd;
      else if (phase[k] < 0) m_din[k] = ext_dq_i;
      if (sram_oe && !acc) m_ovf[k] = 1'b1;
      if (pop_now) begin
        qpop(k, e);
        cur[k]   = e;
        phase[k] = 0;
      end else if (phase[k] == ws_of[k] + 1) begin
        phase[k] = -1;
      end else if (phase[k] >= 0) begin
        phase[k] = phase[k] + 1;
      end
      if (acc) qpush(k, {addr, sram_dout});
      act[k] = 1'b1;
    end
  endtask

  task automatic cyc(input bit we, input logic [15:0] a, input logic [7:0] d, input logic [7:0] dqi);
    @(negedge clk);
    sram_oe   = we;
    addr      = a;
    sram_dout = d;
    ext_dq_i  = dqi;
    #1;
    check_outputs();
    model_step();
  endtask

  task automatic idle_cycles(input int n, input logic [15:0] a);
    for (int i = 0; i < n; i++) cyc(1'b0, a, 8'h00, 8'($urandom));
  endtask

  initial begin
    reset     = 1'b0;
    addr      = 16'h0000;
    sram_oe   = 1'b0;
    sram_dout = 8'h00;
    ext_dq_i  = 8'h00;
    we_low    = '{0, 0};
    model_reset();
    #3;
    check_outputs();
    @(posedge clk);
    #2 reset = 1'b1;

    // Plain read in idle
    idle_cycles(2, 16'h1000);
    cyc(1'b0, 16'h0123, 8'h00, 8'h5A);
    cyc(1'b0, 16'h0123, 8'h00, 8'h00);
    chk("read_5a_ws1", sram_din[0], 8'h5A);
    chk("read_5a_ws4", sram_din[1], 8'h5A);

    // Single write: pulse width equals WS
    we_low = '{0, 0};
    cyc(1'b1, 16'h0040, 8'hA5, 8'h00);
    idle_cycles(10, 16'h1000);
    chk("single_pulses_ws1", we_low[0], 1);
    chk("single_pulses_ws4", we_low[1], 4);

    // Three back-to-back writes
    we_low = '{0, 0};
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h01FD + 16'(i), 8'(i + 1), 8'h00);
    idle_cycles(20, 16'h1000);
    chk("three_pulses_ws1", we_low[0], 3);
    chk("three_pulses_ws4", we_low[1], 12);
    chk("three_ovf_ws1", ovf[0], 0);
    chk("three_ovf_ws4", ovf[1], 0);

    // Read of a write still being pulsed is forwarded
    cyc(1'b1, 16'h0200, 8'h77, 8'h00);
    for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0200, 8'h00, 8'h11);
    chk("fwd_in_pulse_we_n", ext_we_n[1], 0);
    chk("fwd_in_pulse_din", sram_din[1], 8'h77);
    idle_cycles(10, 16'h1000);

    // Six writes into a 4-deep FIFO
    we_low = '{0, 0};
    for (int i = 0; i < 6; i++) cyc(1'b1, 16'h0300 + 16'(i), 8'h10 + 8'(i), 8'h00);
    idle_cycles(1, 16'h1000);
    chk("burst_ovf_ws4", ovf[1], 1);
    chk("burst_ovf_ws1", ovf[0], 0);
    idle_cycles(40, 16'h1000);
    chk("burst_ovf_held_ws4", ovf[1], 1);
    chk("burst_pulses_ws4", we_low[1], 20);
    chk("burst_pulses_ws1", we_low[0], 6);

    // Reset in the middle of a pulse with more writes queued
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0500 + 16'(i), 8'hC0 + 8'(i), 8'h00);
    idle_cycles(1, 16'h1000);
    chk("pre_reset_in_pulse", ext_we_n[1], 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_we_n_now", ext_we_n[1], 1);
    chk("rst_ce_n_now", ext_ce_n[1], 1);
    model_reset();
    check_outputs();
    @(posedge clk);
    #2 reset = 1'b1;
    we_low = '{0, 0};
    idle_cycles(20, 16'h1000);
    chk("post_reset_pulses_ws1", we_low[0], 0);
    chk("post_reset_pulses_ws4", we_low[1], 0);

    // Randomized traffic over a small address window to exercise forwarding
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 2) == 0, 16'h0700 + 16'($urandom_range(0, 7)),
          8'($urandom), 8'($urandom));
    idle_cycles(40, 16'h0700);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
